// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
// Glyphs are active-low with segments a..g on bits [0]..[6].
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/display_scan_if.sv
// Frame load handshake between the BCD producer and the scan scheduler.
// The master offers digits_in/load_valid; the slave returns load_ready.
interface display_scan_if;
  import display_pkg::*;

  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   digits_in;

  modport master (
    output load_valid,
    output digits_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  digits_in,
    output load_ready
  );
endinterface

// File: rtl/display_scan_scheduler_hex.sv
// hex_to_7seg_ca: nibble to active-low common-anode glyph decoder.
// Full hex set: values above 9 render as A b C d E F.
module hex_to_7seg_ca
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  always_comb begin
    glyph = SEG_OFF;
    unique case (nib)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end
endmodule

// File: rtl/display_scan_scheduler.sv
// Double-buffered 4-digit scan controller with dead-time blanking.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int F_CLK_HZ     = 50_000_000,
  parameter int REFRESH_HZ   = 4000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  display_scan_if.slave  ld,
  output logic [6:0]     seg,
  output logic [3:0]     an,
  output logic [1:0]     digit_idx,
  output logic           frame_start
);
  localparam int SLOT = F_CLK_HZ / REFRESH_HZ;
  localparam int CW   = $clog2(SLOT);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(SLOT - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    idx_n;
  logic          wrap;
  logic [15:0]   active;
  logic [15:0]   pend_buf;
  logic          pending;
  logic          xfer;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          lz;

  // IDLE drains pending itself, so the producer is never stalled there
  assign ld.load_ready = (state == ST_IDLE) | ~pending;
  assign xfer = ld.load_valid & ld.load_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = digit_idx;
    wrap    = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          idx_n   = '0;
          wrap    = 1'b1;
        end
        ST_BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == BLANK_END)
            state_n = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt == SLOT_END) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            idx_n   = digit_idx + 2'd1;
            wrap    = (digit_idx == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    nib = active[3:0];
    unique case (digit_idx)
      2'd0: nib = active[3:0];
      2'd1: nib = active[7:4];
      2'd2: nib = active[11:8];
      2'd3: nib = active[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz = 1'b0;
    unique case (digit_idx)
      2'd3: lz = (active[15:12] == 4'h0);
      2'd2: lz = (active[15:8] == 8'h00);
      2'd1: lz = (active[15:4] == 12'h000);
      2'd0: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  hex_to_7seg_ca u_hex (
    .nib   (nib),
    .glyph (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= '0;
      pend_buf <= '0;
      pending  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (xfer)
        active <= ld.digits_in;
      else if (pending)
        active <= pend_buf;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        active  <= pend_buf;
        pending <= 1'b0;
      end
      if (xfer) begin
        pend_buf <= ld.digits_in;
        pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      digit_idx   <= idx_n;
      frame_start <= wrap;
      if (en && state == ST_DRIVE) begin
        an  <= ~(4'b0001 << digit_idx);
        seg <= lz ? SEG_OFF : glyph;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler: SLOT=10, BLANK=2, 40-cycle frame.
// Honours LEADING_ZERO_BLANK_EN in its expected glyphs.
module tb_display_scan_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_start;

  int n_assert = 0;
  int n_fail   = 0;
  int j        = 0;

  logic [15:0] exp_frame [0:7];
  logic [6:0]  glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  display_scan_if bus ();

  display_scan_scheduler #(
    .F_CLK_HZ     (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ld          (bus),
    .seg         (seg),
    .an          (an),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d: observed %0h expected %0h",
             tag, j, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    j++;
  endtask

  function automatic logic [15:0] fval(input int k);
    return 16'((k * 40503 + 12345) & 16'hFFFF);
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] f,
                                         input int d);
    logic [15:0] hi;
    hi = f >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && hi == 16'h0)
      return 7'h7F;
`endif
    return glyph_tab[hi[3:0]];
  endfunction

  // outputs lag the scan state by one cycle; digit_idx does not
  task automatic check_cycle();
    int p, c, d;
    logic [3:0] ea;
    logic [6:0] es;
    p  = j - 1;
    c  = p % 10;
    d  = (p / 10) % 4;
    ea = 4'hF;
    es = 7'h7F;
    if (c >= 2) begin
      ea[d] = 1'b0;
      es    = exp_seg(exp_frame[p / 40], d);
    end
    chk("an", {12'h0, an}, {12'h0, ea});
    chk("seg", {9'h0, seg}, {9'h0, es});
    chk("idx", {14'h0, digit_idx}, 16'((j / 10) % 4));
    chk("frame_start", {15'h0, frame_start}, 16'(j % 40 == 0));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      check_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    bus.load_valid = 1'b0;
    bus.digits_in  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {9'h0, seg}, 16'h7F);
    chk("rst_an", {12'h0, an}, 16'hF);
    chk("rst_idx", {14'h0, digit_idx}, 16'h0);
    chk("rst_fs", {15'h0, frame_start}, 16'h0);
    chk("rst_ready", {15'h0, bus.load_ready}, 16'h1);
    rst = 1'b0;

    // load 1234 while idle, then start scanning
    bus.load_valid = 1'b1;
    bus.digits_in  = 16'h1234;
    tick();
    chk("idle_ready", {15'h0, bus.load_ready}, 16'h1);
    bus.load_valid = 1'b0;
    en = 1'b1;
    exp_frame[0] = 16'h1234;
    exp_frame[1] = 16'h1234;
    exp_frame[2] = 16'h5678;
    tick();
    j = 0;
    chk("start_fs", {15'h0, frame_start}, 16'h1);
    chk("start_an", {12'h0, an}, 16'hF);
    chk("start_idx", {14'h0, digit_idx}, 16'h0);

    // mid-frame load is deferred to the boundary
    run(45);
    bus.load_valid = 1'b1;
    bus.digits_in  = 16'h5678;
    run(1);
    bus.load_valid = 1'b0;
    chk("ready_low", {15'h0, bus.load_ready}, 16'h0);
    run(33);
    chk("ready_pre", {15'h0, bus.load_ready}, 16'h0);
    run(1);
    chk("ready_post", {15'h0, bus.load_ready}, 16'h1);

    // continuous offers: one transfer per frame
    exp_frame[3] = fval(80);
    exp_frame[4] = fval(120);
    bus.load_valid = 1'b1;
    while (j < 159) begin
      bus.digits_in = fval(j);
      run(1);
    end
    bus.load_valid = 1'b0;
    while (j < 185) run(1);

    // abort mid-DRIVE of digit 2
    en = 1'b0;
    tick();
    chk("abort_an", {12'h0, an}, 16'hF);
    chk("abort_seg", {9'h0, seg}, 16'h7F);
    chk("abort_idx", {14'h0, digit_idx}, 16'h0);
    repeat (3) tick();
    chk("idle_an", {12'h0, an}, 16'hF);
    en = 1'b1;
    tick();
    j = 0;
    exp_frame[0] = fval(120);
    chk("restart_fs", {15'h0, frame_start}, 16'h1);
    chk("restart_idx", {14'h0, digit_idx}, 16'h0);
    run(5);
    bus.load_valid = 1'b1;
    bus.digits_in  = 16'hBEEF;
    run(1);
    bus.load_valid = 1'b0;
    chk("pend_ready", {15'h0, bus.load_ready}, 16'h0);
    run(9);

    // asynchronous reset with a pending frame
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("arst_seg", {9'h0, seg}, 16'h7F);
    chk("arst_an", {12'h0, an}, 16'hF);
    chk("arst_idx", {14'h0, digit_idx}, 16'h0);
    chk("arst_ready", {15'h0, bus.load_ready}, 16'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {15'h0, bus.load_ready}, 16'h1);
    en = 1'b1;
    tick();
    j = 0;
    exp_frame[0] = 16'h0000;
    chk("post_rst_fs", {15'h0, frame_start}, 16'h1);
    run(12);

    // leading zero frame
    en = 1'b0;
    tick();
    bus.load_valid = 1'b1;
    bus.digits_in  = 16'h00A0;
    tick();
    bus.load_valid = 1'b0;
    en = 1'b1;
    tick();
    j = 0;
    exp_frame[0] = 16'h00A0;
    exp_frame[1] = 16'h00A0;
    run(35);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_digit3", {9'h0, seg}, 16'h7F);
`else
    chk("lz_digit3", {9'h0, seg}, 16'h40);
`endif
    chk("lz_an3", {12'h0, an}, 16'h7);
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
